// File: rtl/sp_ram_init_pkg.sv
// Shared types and constants for the single-port RAM initiator.
package sp_ram_init_pkg;

  // Which requester owns the RAM port in the current cycle.
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;

  // Cycles from driving ram_addr until the matching ram_dout can be sampled.
  localparam int RAM_RD_LATENCY = 2;

endpackage

// File: rtl/sp_ram_rsp_buffer.sv
// Read-response FIFO: DEPTH entries, push from the tag pipe, valid/ready pop.
module sp_ram_rsp_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  full;

  // Pointer increment that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop       = pop_valid && pop_ready;
  assign pop_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_data  = mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: data storage has no reset -- the count/pointers define validity,
  // and leaving the array unreset lets it map onto plain register files.
  always_ff @(posedge clk) begin
    if (push_valid) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr <= ptr_inc(rd_ptr);
      case ({push_valid, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit scheme upstream guarantees a free slot for every push.
  assert property (@(posedge clk) disable iff (rst) !(push_valid && full))
    else $error("sp_ram_rsp_buffer: push while full");

endmodule

// File: rtl/sp_ram_initiator.sv
// Per-bank port controller for one single_port_RAM (registered inputs,
// 2-cycle read). Arbitrates write/read requests onto the RAM port, tracks
// in-flight reads with a credit counter and returns data in issue order.
// Optional: SP_RAM_INIT_RR_ARB_EN selects round-robin on wr/rd conflicts;
// otherwise writes win every conflict.
module sp_ram_initiator
  import sp_ram_init_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 256,
  parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH),
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [LB_RAM_DEPTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [LB_RAM_DEPTH-1:0] rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [LB_RAM_DEPTH-1:0] ram_addr,
  output logic                    ram_wr_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  grant_e                      grant;
  grant_e                      ptr_q;
  grant_e                      ptr_d;
  logic                        rd_eligible;
  logic                        rd_req;
  logic                        rd_issue;
  logic                        rsp_pop;
  logic [CW-1:0]               credit_q;
  logic [RAM_RD_LATENCY-1:0]   tag_q;
  logic [LB_RAM_DEPTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]       din_q;

  // A read may issue only if its response is guaranteed a buffer slot.
  assign rd_eligible = (credit_q < CW'(RSP_DEPTH));
  assign rd_req      = rd_valid && rd_eligible;
  assign wr_ready    = (grant == GNT_WR);
  assign rd_ready    = (grant == GNT_RD);
  assign rd_issue    = rd_ready;
  assign rsp_pop     = rsp_valid && rsp_ready;

  // Arbiter: pick at most one requester per cycle; nothing is granted in reset.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    grant = GNT_NONE;
    ptr_d = ptr_q;
    if (!rst) begin
`ifdef SP_RAM_INIT_RR_ARB_EN
      if (wr_valid && rd_req) begin
        grant = ptr_q;
        ptr_d = (ptr_q == GNT_WR) ? GNT_RD : GNT_WR;
      end else if (wr_valid) begin
        grant = GNT_WR;
      end else if (rd_req) begin
        grant = GNT_RD;
      end
`else
      if (wr_valid) begin
        grant = GNT_WR;
      end else if (rd_req) begin
        grant = GNT_RD;
      end
`endif
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= GNT_WR;
    else     ptr_q <= ptr_d;
  end

  // RAM port drive: follows the grant, otherwise holds the last address/data.
  always_comb begin
    ram_wr_en = (grant == GNT_WR);
    ram_addr  = addr_q;
    ram_din   = din_q;
    case (grant)
      GNT_WR: begin
        ram_addr = wr_addr;
        ram_din  = wr_data;
      end
      GNT_RD:  ram_addr = rd_addr;
      default: ;
    endcase
    if (rst) begin
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  // Remember the last driven address/data so idle cycles keep them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      addr_q <= ram_addr;
      din_q  <= ram_din;
    end
  end

  // Tag pipe: marks the cycle in which a read's ram_dout is valid.
  always_ff @(posedge clk) begin
    if (rst) tag_q <= '0;
    else     tag_q <= {tag_q[RAM_RD_LATENCY-2:0], rd_issue};
  end

  // Credit = reads in flight plus responses waiting in the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      case ({rd_issue, rsp_pop})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

  sp_ram_rsp_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_buffer (
    .clk        (clk),
    .rst        (rst),
    .push_valid (tag_q[RAM_RD_LATENCY-1]),
    .push_data  (ram_dout),
    .pop_valid  (rsp_valid),
    .pop_ready  (rsp_ready),
    .pop_data   (rsp_data)
  );

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Directed self-checking bench for sp_ram_initiator with a behavioural
// single_port_RAM (registered din/addr/wr_en, read-first, 2-cycle read).
module tb_sp_ram_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data, ram_din, ram_addr, ram_dout;
  logic       ram_wr_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sp_ram_initiator #(
    .DATA_WIDTH (8),
    .RAM_DEPTH  (256),
    .RSP_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_din   (ram_din),
    .ram_addr  (ram_addr),
    .ram_wr_en (ram_wr_en),
    .ram_dout  (ram_dout)
  );

  // Behavioural RAM: inputs registered, array access one cycle later.
  logic [7:0] mem [256];
  logic [7:0] addr_r = '0;
  logic [7:0] din_r  = '0;
  logic       we_r   = 1'b0;
  always @(posedge clk) begin
    addr_r <= ram_addr;
    din_r  <= ram_din;
    we_r   <= ram_wr_en;
    if (we_r) mem[addr_r] <= din_r;
    ram_dout <= mem[addr_r];
  end

  // Handshake monitor, sampled mid-cycle.
  int         wr_hs = 0;
  int         rd_hs = 0;
  logic [7:0] rsp_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) wr_hs++;
      if (rd_valid && rd_ready) rd_hs++;
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_count"}, rsp_q.size(), n);
  endtask

  // Stream reads from base, advancing only on acceptance; returns accept count.
  task automatic stream_reads(input logic [7:0] base, input int cycles, output int acc);
    logic [7:0] a = base;
    acc = 0;
    for (int c = 0; c < cycles; c++) begin
      rd_valid = 1'b1;
      rd_addr  = a;
      #1;
      if (rd_ready) begin
        a++;
        acc++;
      end
      tick();
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    int         acc, lat, bad, w0, r0, exp_wr, exp_rd;
    logic [7:0] ea;

    // Reset with both requesters active: nothing may be granted.
    rst = 1'b1; rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
    rd_valid = 1'b1; rd_addr = 8'h44;
    repeat (3) tick();
    check("rst_wr_ready",  wr_ready,  0);
    check("rst_rd_ready",  rd_ready,  0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ram_wr_en", ram_wr_en, 0);
    check("rst_ram_addr",  ram_addr,  0);
    check("rst_ram_din",   ram_din,   0);
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    tick();

    // 1: write then read-after-write, latency 3.
    wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5;
    #1;
    check("t1_wr_ready", wr_ready,  1);
    check("t1_wr_en",    ram_wr_en, 1);
    check("t1_ram_addr", ram_addr,  8'h10);
    check("t1_ram_din",  ram_din,   8'hA5);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h10;
    #1;
    check("t1_rd_ready", rd_ready, 1);
    check("t1_rd_wr_en", ram_wr_en, 0);
    lat = 0;
    do begin
      tick();
      rd_valid = 1'b0;
      lat++;
      #1;
    end while (!rsp_valid && lat < 10);
    check("t1_latency",  lat,      3);
    check("t1_rsp_data", rsp_data, 8'hA5);
    tick();

    // 6: fill every address with addr^0x5A, read all back in order.
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      wr_valid = 1'b1; wr_addr = 8'(a); wr_data = 8'(a) ^ 8'h5A;
      #1;
      if (!wr_ready) bad++;
      tick();
    end
    wr_valid = 1'b0;
    check("t6_wr_stalls", bad, 0);
    rsp_q.delete();
    stream_reads(8'h00, 256, acc);
    check("t6_rd_accepted", acc, 256);
    wait_rsp(256, 20, "t6");
    for (int i = 0; i < rsp_q.size(); i++) begin
      ea = 8'(i);
      check($sformatf("t6_data_%0d", i), rsp_q[i], ea ^ 8'h5A);
    end

    // 2: 16 back-to-back reads across the 255->0 wrap, no stalls.
    rsp_q.delete();
    stream_reads(8'd248, 16, acc);
    check("t2_rd_accepted", acc, 16);
    wait_rsp(16, 20, "t2");
    for (int i = 0; i < rsp_q.size(); i++) begin
      ea = 8'(248 + i);
      check($sformatf("t2_data_%0d", i), rsp_q[i], ea ^ 8'h5A);
    end
    check("t2_hold_addr",  ram_addr,  8'h07);
    check("t2_hold_din",   ram_din,   8'hA5);
    check("t2_hold_wr_en", ram_wr_en, 0);

    // 3: responses back-pressured: 4 reads accepted, then stall; writes continue.
    rsp_q.delete();
    rsp_ready = 1'b0;
    stream_reads(8'h40, 10, acc);
    check("t3_rd_accepted", acc, 4);
    rd_valid = 1'b1; rd_addr = 8'h44;
    wr_valid = 1'b1; wr_addr = 8'h41; wr_data = 8'h41 ^ 8'h5A;
    #1;
    check("t3_rd_ready_full", rd_ready,  0);
    check("t3_wr_ready_full", wr_ready,  1);
    check("t3_rsp_valid",     rsp_valid, 1);
    check("t3_rsp_data_hold", rsp_data,  8'h40 ^ 8'h5A);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("t3_rsp_data_stable", rsp_data, 8'h40 ^ 8'h5A);
    rsp_ready = 1'b1;
    wait_rsp(4, 10, "t3");
    for (int i = 0; i < rsp_q.size(); i++) begin
      ea = 8'(8'h40 + i);
      check($sformatf("t3_data_%0d", i), rsp_q[i], ea ^ 8'h5A);
    end

    // 4: write and read both held for 8 cycles.
`ifdef SP_RAM_INIT_RR_ARB_EN
    exp_wr = 4; exp_rd = 4;
`else
    exp_wr = 8; exp_rd = 0;
`endif
    rsp_q.delete();
    w0 = wr_hs; r0 = rd_hs;
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 8'h20 ^ 8'h5A;
    rd_valid = 1'b1; rd_addr = 8'h30;
    repeat (8) tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("t4_wr_grants", wr_hs - w0, exp_wr);
    check("t4_rd_grants", rd_hs - r0, exp_rd);
    repeat (8) tick();
    check("t4_rsp_count", rsp_q.size(), exp_rd);
    for (int i = 0; i < rsp_q.size(); i++)
      check($sformatf("t4_data_%0d", i), rsp_q[i], 8'h30 ^ 8'h5A);

    // 5: reset with two reads in flight drops them; credit restarts at 0.
    rsp_q.delete();
    rd_valid = 1'b1; rd_addr = 8'h50;
    #1;
    check("t5_rd0_ready", rd_ready, 1);
    tick();
    rd_addr = 8'h51;
    #1;
    check("t5_rd1_ready", rd_ready, 1);
    tick();
    rd_valid = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t5_no_rsp",    rsp_q.size(), 0);
    check("t5_rsp_valid", rsp_valid,    0);
    rsp_ready = 1'b0;
    stream_reads(8'h60, 8, acc);
    check("t5_credit_accepted", acc, 4);
    rsp_ready = 1'b1;
    wait_rsp(4, 10, "t5");
    for (int i = 0; i < rsp_q.size(); i++) begin
      ea = 8'(8'h60 + i);
      check($sformatf("t5_data_%0d", i), rsp_q[i], ea ^ 8'h5A);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
